// File: rtl/hue_decay_pkg.sv
// Shared constants and types for the hue/decay LED engine.
package hue_decay_pkg;

   localparam logic [8:0] HUE_MAX = 9'd359;

   typedef enum logic {
      DECAY_LINEAR = 1'b0,
      DECAY_EXP    = 1'b1
   } decay_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_EMIT  = 2'd3
   } decay_state_e;

endpackage

// File: rtl/hue_sweep_gen.sv
// Hue accumulator: slow +1 sweep plus a BEAT_STEP jump on each beat rising edge.
module hue_sweep_gen
   import hue_decay_pkg::*;
#(
   parameter int HUE_TICK  = 10_000_000,
   parameter int BEAT_STEP = 60
) (
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic       beat_in,
   output logic [8:0] hue
);

   localparam int TW = (HUE_TICK > 1) ? $clog2(HUE_TICK) : 1;

   logic [TW-1:0] sweep_cnt;
   logic          sweep_tick;
   logic          beat_q;
   logic          beat_edge;
   logic [9:0]    hue_raw;
   logic [9:0]    hue_next;

   assign sweep_tick = (sweep_cnt == TW'(HUE_TICK - 1));
   assign beat_edge  = beat_in & ~beat_q;

   // Worst case 359 + 359 + 1 < 720, so one conditional subtract suffices.
   always_comb begin
      hue_raw  = {1'b0, hue} + (beat_edge ? 10'(BEAT_STEP) : 10'd0) + (sweep_tick ? 10'd1 : 10'd0);
      hue_next = (hue_raw > {1'b0, HUE_MAX}) ? hue_raw - 10'd360 : hue_raw;
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         sweep_cnt <= '0;
         beat_q    <= 1'b0;
         hue       <= '0;
      end else begin
         sweep_cnt <= sweep_tick ? '0 : sweep_cnt + TW'(1);
         beat_q    <= beat_in;
         hue       <= hue_next[8:0];
      end
   end

endmodule

// File: rtl/hue_decay_engine.sv
// Per-LED brightness store fed by magnitude strobes, decayed and emitted one LED per decay tick.
module hue_decay_engine
   import hue_decay_pkg::*;
#(
   parameter int NUM_LEDS   = 72,
   parameter int VAL_W      = 8,
   parameter int HUE_TICK   = 10_000_000,
   parameter int DECAY_TICK = 2500,
   parameter int BEAT_STEP  = 60
) (
   input  logic                        clk_100mhz,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [VAL_W-1:0]            in_mag,
   input  logic                        in_last,
   input  logic [VAL_W-1:0]            threshold,
   input  logic                        beat_in,
   input  logic                        decay_mode,
   input  logic                        peak_hold,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [$clog2(NUM_LEDS)-1:0] out_index,
   output logic [8:0]                  out_hue,
   output logic [VAL_W-1:0]            out_val
);

   localparam int IDX_W = $clog2(NUM_LEDS);
   localparam int DW    = (DECAY_TICK > 1) ? $clog2(DECAY_TICK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

   logic [VAL_W-1:0] mem [NUM_LEDS];

   decay_state_e     state;
   logic [IDX_W-1:0] in_idx, scan_idx, clr_idx;
   logic             clr_active;
   logic [DW-1:0]    decay_cnt;
   logic             decay_tick, decay_pending, consume;
   logic [VAL_W-1:0] rd_val, dec_step, dec_val, in_cur, in_wdata;
   logic             in_wr, collide, same_addr;
   logic [8:0]       hue;

   hue_sweep_gen #(
      .HUE_TICK  (HUE_TICK),
      .BEAT_STEP (BEAT_STEP)
   ) u_hue (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .beat_in    (beat_in),
      .hue        (hue)
   );

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   assign in_cur    = mem[in_idx];
   assign in_wdata  = (peak_hold && in_cur > in_mag) ? in_cur : in_mag;
   assign in_wr     = in_valid && !clr_active && (in_mag > threshold);
   assign same_addr = (in_idx == scan_idx);
   assign collide   = (state == ST_WRITE) && in_wr;
   assign decay_tick = (decay_cnt == DW'(DECAY_TICK - 1));
   assign consume   = (state == ST_IDLE) && decay_pending && !clr_active;

   always_comb begin
      dec_step = VAL_W'(1);
      if (decay_mode_e'(decay_mode) == DECAY_EXP && (rd_val >> 3) != '0)
         dec_step = rd_val >> 3;
      dec_val = (rd_val > dec_step) ? rd_val - dec_step : '0;
   end

   // Single write port: clear sweep, then input, then decay writeback.
   always_ff @(posedge clk_100mhz) begin
      if (clr_active)
         mem[clr_idx] <= '0;
      else if (in_wr)
         mem[in_idx] <= in_wdata;
      else if (state == ST_WRITE)
         mem[scan_idx] <= dec_val;
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         clr_active    <= 1'b1;
         clr_idx       <= '0;
         in_idx        <= '0;
         decay_cnt     <= '0;
         decay_pending <= 1'b0;
      end else begin
         if (clr_active) begin
            clr_idx <= idx_inc(clr_idx);
            if (clr_idx == LAST_IDX)
               clr_active <= 1'b0;
         end else if (in_valid) begin
            in_idx <= in_last ? '0 : idx_inc(in_idx);
         end
         decay_cnt     <= decay_tick ? '0 : decay_cnt + DW'(1);
         // Ticks arriving while already pending collapse into the one event.
         decay_pending <= decay_tick | (decay_pending & ~consume);
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         scan_idx  <= '0;
         rd_val    <= '0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_hue   <= '0;
         out_val   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (consume) state <= ST_READ;
            ST_READ: begin
               rd_val <= (in_wr && same_addr) ? in_wdata : mem[scan_idx];
               state  <= ST_WRITE;
            end
            // A colliding input to another LED stalls the writeback one cycle;
            // to the same LED it replaces the decayed value outright.
            ST_WRITE: if (!collide || same_addr) begin
               out_valid <= 1'b1;
               out_index <= scan_idx;
               out_hue   <= hue;
               out_val   <= collide ? in_wdata : dec_val;
               state     <= ST_EMIT;
            end
            ST_EMIT: if (out_ready) begin
               out_valid <= 1'b0;
               scan_idx  <= idx_inc(scan_idx);
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hue_decay_engine.sv
// Directed bench for hue_decay_engine with 4 LEDs, 8-clock decay tick, 16-clock hue sweep.
module tb_hue_decay_engine;

   localparam int NUM_LEDS = 4;
   localparam int VAL_W    = 8;
   localparam int IDX_W    = 2;

   logic             clk_100mhz = 1'b0;
   logic             rst        = 1'b1;
   logic             in_valid   = 1'b0;
   logic [VAL_W-1:0] in_mag     = '0;
   logic             in_last    = 1'b0;
   logic [VAL_W-1:0] threshold  = 8'd10;
   logic             beat_in    = 1'b0;
   logic             decay_mode = 1'b0;
   logic             peak_hold  = 1'b0;
   logic             out_ready  = 1'b1;
   logic             out_valid;
   logic [IDX_W-1:0] out_index;
   logic [8:0]       out_hue;
   logic [VAL_W-1:0] out_val;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   hue_decay_engine #(
      .NUM_LEDS   (NUM_LEDS),
      .VAL_W      (VAL_W),
      .HUE_TICK   (16),
      .DECAY_TICK (8),
      .BEAT_STEP  (60)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_mag     (in_mag),
      .in_last    (in_last),
      .threshold  (threshold),
      .beat_in    (beat_in),
      .decay_mode (decay_mode),
      .peak_hold  (peak_hold),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_index  (out_index),
      .out_hue    (out_hue),
      .out_val    (out_val)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   // Edges since reset release; edge 1 is the first posedge with rst low.
   always @(posedge clk_100mhz) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge clk_100mhz);
         #1;
         guard++;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_index", int'(out_index), 0);
      chk("rst_val",   int'(out_val),   0);
      chk("rst_hue",   int'(dut.u_hue.hue), 0);
      repeat (2) @(negedge clk_100mhz);
      rst = 1'b0;
   endtask

   task automatic get_emit(input string tag, input int e_idx, input int e_val, input int e_hue);
      int seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         @(negedge clk_100mhz);
         if (out_valid) seen = 1;
      end
      if (seen == 0) chk({tag, "_timeout"}, seen, 1);
      else begin
         chk({tag, "_idx"}, int'(out_index), e_idx);
         chk({tag, "_val"}, int'(out_val), e_val);
         if (e_hue >= 0) chk({tag, "_hue"}, int'(out_hue), e_hue);
      end
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic drive_in(input int at, input int mag, input logic last);
      wait_cyc(at);
      in_valid = 1'b1;
      in_mag   = VAL_W'(mag);
      in_last  = last;
   endtask

   task automatic idle_in(input int at);
      wait_cyc(at);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int changes, cnt, first, idx2, s_idx, s_val, s_hue;

      // Idle after reset: clear sweep then zeros emitted in scan order.
      do_reset();
      get_emit("t1_e0", 0, 0, 0);
      get_emit("t1_e1", 1, 0, 1);
      get_emit("t1_e2", 2, 0, 1);
      get_emit("t1_e3", 3, 0, 2);
      get_emit("t1_e4", 0, 0, 2);

      // Linear, overwrite, threshold exclusive.
      do_reset();
      drive_in(5, 9, 1'b0);
      drive_in(6, 200, 1'b0);
      drive_in(7, 10, 1'b0);
      idle_in(8);
      get_emit("t2_e0", 0, 0, -1);
      get_emit("t2_e1", 1, 199, -1);
      get_emit("t2_e2", 2, 0, -1);
      get_emit("t2_e3", 3, 0, -1);
      get_emit("t2_e4", 0, 0, -1);
      get_emit("t2_e5", 1, 198, -1);

      // Exponential with peak hold; in_last sends the next magnitude back to index 0.
      decay_mode = 1'b1;
      peak_hold  = 1'b1;
      do_reset();
      drive_in(5, 150, 1'b1);
      drive_in(6, 100, 1'b0);
      drive_in(7, 12, 1'b0);
      idle_in(8);
      get_emit("t3_e0", 0, 132, -1);
      get_emit("t3_e1", 1, 11, -1);
      get_emit("t3_e2", 2, 0, -1);
      get_emit("t3_e3", 3, 0, -1);
      get_emit("t3_e4", 0, 116, -1);
      get_emit("t3_e5", 1, 10, -1);
      decay_mode = 1'b0;
      peak_hold  = 1'b0;

      // Collisions in WRITE: same index (edge 11) and a different index (edge 19).
      do_reset();
      drive_in(10, 77, 1'b1);
      idle_in(11);
      get_emit("t6_e0", 0, 77, -1);
      chk("t6_mem0", int'(dut.mem[0]), 77);
      drive_in(18, 50, 1'b0);
      idle_in(19);
      get_emit("t6_e1", 1, 0, -1);
      get_emit("t6_e2", 2, 0, -1);
      get_emit("t6_e3", 3, 0, -1);
      get_emit("t6_e4", 0, 49, -1);

      // Backpressure: 50 stalled cycles, then exactly one queued event.
      out_ready = 1'b0;
      do_reset();
      cnt = 0;
      for (int i = 0; i < 100 && cnt == 0; i++) begin
         @(negedge clk_100mhz);
         if (out_valid) cnt = 1;
      end
      chk("t5_first_valid", cnt, 1);
      s_idx = int'(out_index);
      s_val = int'(out_val);
      s_hue = int'(out_hue);
      chk("t5_stall_idx", s_idx, 0);
      changes = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_100mhz);
         if (!out_valid || int'(out_index) != s_idx || int'(out_val) != s_val || int'(out_hue) != s_hue)
            changes++;
      end
      chk("t5_stable", changes, 0);
      out_ready = 1'b1;
      cnt   = 0;
      first = -1;
      idx2  = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_100mhz);
         if (out_valid) begin
            if (first < 0) begin
               first = i;
               idx2  = int'(out_index);
            end
            cnt++;
         end
      end
      chk("t5_queued_lat", first, 3);
      chk("t5_queued_idx", idx2, 1);
      chk("t5_emit_count", cnt, 3);
      out_ready = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100 && cnt == 0; i++) begin
         @(negedge clk_100mhz);
         if (out_valid) cnt = 1;
      end
      chk("t5_restall", cnt, 1);
      out_ready = 1'b1;

      // Mid-handshake reset drops the sample; then hue wrap with coincident beat and sweep.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         wait_cyc(20 + 20 * k);
         beat_in = 1'b1;
         wait_cyc(21 + 20 * k);
         beat_in = 1'b0;
      end
      wait_cyc(495);
      chk("hue_330", int'(dut.u_hue.hue), 330);
      beat_in = 1'b1;
      wait_cyc(496);
      chk("hue_wrap", int'(dut.u_hue.hue), 31);
      wait_cyc(520);
      chk("hue_held_beat", int'(dut.u_hue.hue), 32);
      beat_in = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
